// File: rtl/mac_pkg.sv
// Shared definitions for the pipelined multiply-accumulate unit: operation
// mode encodings, the Booth digit record and the accumulator width rule.
package mac_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  // One recoded multiplier digit: magnitude one-hot (single, double, triple,
  // quad) plus negate. Radix-4 only ever produces single/double; triple and
  // quad are for higher-radix recoders sharing this record.
  typedef struct packed {
    logic s;
    logic d;
    logic t;
    logic q;
    logic n;
  } booth_dig_t;

  function automatic int acc_w_f(input int width, input int guard);
    return 2 * width + guard;
  endfunction

  // Radix-4 recoding of the overlapping triplet {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_dig_t booth_enc(input logic [2:0] b);
    booth_dig_t dig;
    dig.s = b[1] ^ b[0];
    dig.d = (b[2] & ~b[1] & ~b[0]) | (~b[2] & b[1] & b[0]);
    dig.t = 1'b0;
    dig.q = 1'b0;
    dig.n = b[2] & ~(b[1] & b[0]);
    return dig;
  endfunction

endpackage

// File: rtl/booth_mul_r4.sv
// Combinational radix-4 Booth multiplier, (WIDTH+1)-bit signed operands to a
// (2*WIDTH+2)-bit signed product. Unsigned callers zero-extend beforehand.
module booth_mul_r4
  import mac_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH:0]     a_i,
  input  logic signed [WIDTH:0]     b_i,
  output logic signed [2*WIDTH+1:0] p_o
);

  localparam int PW = 2 * WIDTH + 2;
  localparam int ND = (WIDTH + 2) / 2;

  // Multiplier sign-extended to an even length, with the implicit zero below bit 0.
  logic [WIDTH+2:0]      bx;
  logic signed [PW-1:0]  a_ext;
  logic signed [PW-1:0]  pp;
  logic signed [PW-1:0]  sum;
  booth_dig_t            dig;

  assign bx    = {b_i[WIDTH], b_i, 1'b0};
  assign a_ext = {{(WIDTH + 1){a_i[WIDTH]}}, a_i};

  // Recode each digit, select its partial product and accumulate modulo 2^PW.
  always_comb begin
    sum = '0;
    pp  = '0;
    dig = '0;
    for (int i = 0; i < ND; i++) begin
      dig = booth_enc(bx[2*i +: 3]);
      pp  = '0;
      if (dig.s)      pp = a_ext;
      else if (dig.d) pp = a_ext <<< 1;
      else if (dig.t) pp = a_ext + (a_ext <<< 1);
      else if (dig.q) pp = a_ext <<< 2;
      if (dig.n) pp = -pp;
      sum = sum + (pp <<< (2 * i));
    end
  end

  assign p_o = sum;

endmodule

// File: rtl/mac_pipe_acc.sv
// Three-stage pipelined multiply-accumulate with valid/ready on both sides,
// signed/unsigned operands per beat, internal accumulator and optional
// saturation. S1 registers operands, S2 registers the product, S3 adds.
module mac_pipe_acc
  import mac_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GUARD = 8,
  parameter int ACC_W = acc_w_f(WIDTH, GUARD),
  parameter bit SAT   = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] mx,
  input  logic [WIDTH-1:0] my,
  input  logic [ACC_W-1:0] az,
  input  logic             sgn,
  input  logic             acc_mode,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] mac,
  output logic             ovf
);

  localparam int PW = 2 * WIDTH;

  logic                    stall, adv, accept;
  logic                    vld_p1, vld_p2, vld_p3;
  logic signed [WIDTH:0]   mxe_p1, mye_p1;
  logic [ACC_W-1:0]        az_p1, az_p2;
  logic                    sgn_p1, sgn_p2, mode_p1, mode_p2, clr_p1, clr_p2;
  logic signed [PW+1:0]    prod_full;
  logic [PW-1:0]           prod_p2;
  logic                    unused_prod_hi;
  logic [ACC_W-1:0]        base, prod_ext;
  logic signed [ACC_W:0]   sum_x;
  logic [ACC_W:0]          sat_res;
  logic [ACC_W-1:0]        acc_q, acc_d, mac_q, mac_d;
  logic                    ovf_q, ovf_d;

  // Clamp an (ACC_W+1)-bit sum to ACC_W bits; MSB of the return is the overflow flag.
  function automatic logic [ACC_W:0] sat_f(input logic signed [ACC_W:0] s);
    logic o;
    o = s[ACC_W] ^ s[ACC_W-1];
    if (!o || !SAT)   return {o, s[ACC_W-1:0]};
    else if (s[ACC_W]) return {1'b1, 1'b1, {(ACC_W - 1){1'b0}}};
    else              return {1'b1, 1'b0, {(ACC_W - 1){1'b1}}};
  endfunction

  assign stall    = vld_p3 & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  booth_mul_r4 #(.WIDTH(WIDTH)) u_mul (
    .a_i (mxe_p1),
    .b_i (mye_p1),
    .p_o (prod_full)
  );

  // The true product always fits 2*WIDTH bits; the top two bits are redundant sign.
  assign unused_prod_hi = ^prod_full[PW+1:PW];

  // S3 operand selection: accumulator or external base, product extended per sign mode.
  always_comb begin
    base = az_p2;
    if (mode_p2 == MODE_ACC && !clr_p2) base = acc_q;
    prod_ext = sgn_p2 ? {{(ACC_W - PW){prod_p2[PW-1]}}, prod_p2}
                      : {{(ACC_W - PW){1'b0}}, prod_p2};
    sum_x    = $signed({base[ACC_W-1], base}) + $signed({prod_ext[ACC_W-1], prod_ext});
    sat_res  = sat_f(sum_x);
  end

  // Next-state for result and accumulator: only a valid beat advancing into S3 updates them.
  always_comb begin
    acc_d = acc_q;
    mac_d = mac_q;
    ovf_d = ovf_q;
    if (adv && vld_p2) begin
      mac_d = sat_res[ACC_W-1:0];
      ovf_d = sat_res[ACC_W];
      if (mode_p2 == MODE_ACC) acc_d = sat_res[ACC_W-1:0];
    end
  end

  // Datapath stage registers, frozen while the output is stalled.
  always_ff @(posedge CLK) begin
    if (adv) begin
      // S0 -> S1
      mxe_p1  <= sgn ? {mx[WIDTH-1], mx} : {1'b0, mx};
      mye_p1  <= sgn ? {my[WIDTH-1], my} : {1'b0, my};
      az_p1   <= az;
      sgn_p1  <= sgn;
      mode_p1 <= acc_mode;
      clr_p1  <= clr;
      // S1 -> S2
      prod_p2 <= prod_full[PW-1:0];
      az_p2   <= az_p1;
      sgn_p2  <= sgn_p1;
      mode_p2 <= mode_p1;
      clr_p2  <= clr_p1;
    end
  end

  // Valid chain, accumulator and result registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      acc_q  <= '0;
      mac_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (adv) begin
        vld_p1 <= accept;
        vld_p2 <= vld_p1;
        vld_p3 <= vld_p2;
      end
      acc_q <= acc_d;
      mac_q <= mac_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = vld_p3;
  assign mac       = mac_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_pipe_acc.sv
module tb_mac_pipe_acc;

  localparam int WIDTH = 16;
  localparam int GUARD = 8;
  localparam int ACC_W = 40;
  localparam longint MAXV = (64'sd1 <<< 39) - 1;
  localparam longint MINV = -(64'sd1 <<< 39);

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] mx = '0;
  logic [WIDTH-1:0] my = '0;
  logic [ACC_W-1:0] az = '0;
  logic             sgn = 1'b0;
  logic             acc_mode = 1'b0;
  logic             clr = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] mac;
  logic             ovf;

  typedef struct {
    logic [ACC_W-1:0] mac;
    logic             ovf;
  } exp_t;

  exp_t             sb[$];
  int               n_chk = 0;
  int               n_fail = 0;
  int               n_push = 0;
  int               n_out = 0;
  longint           model_acc = 0;
  logic [ACC_W-1:0] last_mac = '0;
  logic             last_ovf = 1'b0;
  bit               rnd_bp = 1'b0;

  always #5 CLK = ~CLK;

  mac_pipe_acc #(.WIDTH(WIDTH), .GUARD(GUARD), .SAT(1'b1)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mx        (mx),
    .my        (my),
    .az        (az),
    .sgn       (sgn),
    .acc_mode  (acc_mode),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mac       (mac),
    .ovf       (ovf)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: exact 64-bit arithmetic, then clamp to the signed 40-bit range.
  task automatic push_exp(input logic [15:0] x, input logic [15:0] y, input logic [39:0] a,
                          input logic s, input logic m, input logic c);
    longint p, base, sm;
    logic signed [39:0] as;
    exp_t e;
    as = a;
    if (s) p = longint'($signed(x)) * longint'($signed(y));
    else   p = longint'({48'd0, x}) * longint'({48'd0, y});
    base = (m && !c) ? model_acc : longint'(as);
    sm = base + p;
    e.ovf = 1'b0;
    if (sm > MAXV) begin
      sm = MAXV;
      e.ovf = 1'b1;
    end else if (sm < MINV) begin
      sm = MINV;
      e.ovf = 1'b1;
    end
    e.mac = sm[39:0];
    if (m) model_acc = sm;
    sb.push_back(e);
    n_push++;
  endtask

  // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [39:0] a,
                      input logic s, input logic m, input logic c);
    bit done;
    done = 1'b0;
    mx = x; my = y; az = a; sgn = s; acc_mode = m; clr = c;
    in_valid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      #1;
      if (in_ready) begin
        push_exp(x, y, a, s, m, c);
        done = 1'b1;
      end
      @(posedge CLK);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check_val("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb.size() > 0; t++) @(posedge CLK);
    #1;
    check_val("drain_empty", sb.size(), 0);
  endtask

  // Output monitor: every consumed result is popped from the scoreboard in order.
  always @(negedge CLK) begin
    exp_t e;
    if (RST_N && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_val("unexpected_out", mac, 64'hDEAD);
      end else begin
        e = sb.pop_front();
        check_val($sformatf("mac[%0d]", n_out), mac, e.mac);
        check_val($sformatf("ovf[%0d]", n_out), ovf, e.ovf);
      end
      last_mac = mac;
      last_ovf = ovf;
      n_out++;
    end
  end

  // Random downstream backpressure.
  always @(posedge CLK) begin
    if (rnd_bp) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] ar;
    logic [15:0] xr, yr;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_mac", mac, 0);
    check_val("rst_ovf", ovf, 0);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check_val("rst_in_ready", in_ready, 1);

    // Mode 0 unsigned, latency
    send(16'd3, 16'd5, 40'd10, 1'b0, 1'b0, 1'b0);
    check_val("lat_c1", out_valid, 0);
    @(posedge CLK); #1;
    check_val("lat_c2", out_valid, 0);
    @(posedge CLK); #1;
    check_val("lat_c3", out_valid, 1);
    check_val("lat_mac", mac, 64'd25);
    drain();

    // Signed vs unsigned interpretation
    send(16'hFFFF, 16'd2, 40'd0, 1'b1, 1'b0, 1'b0);
    drain();
    check_val("sgn1_mac", last_mac, 64'hFF_FFFF_FFFE);
    send(16'hFFFF, 16'd2, 40'd0, 1'b0, 1'b0, 1'b0);
    drain();
    check_val("sgn0_mac", last_mac, 64'h1FFFE);

    // Accumulate, back-to-back
    send(16'h0100, 16'h0100, 40'd0, 1'b0, 1'b1, 1'b1);
    repeat (3) send(16'h0100, 16'h0100, 40'd0, 1'b0, 1'b1, 1'b0);
    drain();
    check_val("acc4_mac", last_mac, 64'h40000);

    // Saturation then a zero-product beat
    send(16'd1, 16'h0020, 40'h7F_FFFF_FFF0, 1'b1, 1'b1, 1'b1);
    drain();
    check_val("sat_mac", last_mac, 64'h7F_FFFF_FFFF);
    check_val("sat_ovf", last_ovf, 1);
    send(16'd0, 16'h0020, 40'd0, 1'b1, 1'b1, 1'b0);
    drain();
    check_val("sat_hold_mac", last_mac, 64'h7F_FFFF_FFFF);
    check_val("sat_hold_ovf", last_ovf, 0);

    // clr ignored in mode 0
    send(16'd2, 16'd2, 40'd100, 1'b0, 1'b0, 1'b1);
    drain();
    check_val("mode0_clr_mac", last_mac, 64'd104);

    // Backpressure with three beats in flight
    out_ready = 1'b0;
    send(16'd7, 16'd11, 40'd1, 1'b0, 1'b0, 1'b0);
    send(16'hFFF0, 16'd3, 40'd2, 1'b1, 1'b0, 1'b0);
    send(16'd100, 16'd100, 40'd3, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      check_val($sformatf("bp_in_ready[%0d]", k), in_ready, 0);
      check_val($sformatf("bp_out_valid[%0d]", k), out_valid, 1);
      check_val($sformatf("bp_mac_hold[%0d]", k), mac, sb[0].mac);
    end
    out_ready = 1'b1;
    drain();

    // Random traffic with random backpressure and bubbles
    rnd_bp = 1'b1;
    for (int n = 0; n < 80; n++) begin
      xr = 16'($urandom);
      yr = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       ar = {8'($urandom), 32'($urandom)};
        1:       ar = 40'h7F_FFF0_0000 + 40'($urandom_range(0, 20'hFFFFF));
        default: ar = 40'h80_0000_0000 + 40'($urandom_range(0, 20'hFFFFF));
      endcase
      send(xr, yr, ar, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK); #1;
      end
    end
    rnd_bp = 1'b0;
    @(posedge CLK); #2;
    out_ready = 1'b1;
    drain();

    // Reset with beats in flight
    send(16'd5, 16'd7, 40'd1, 1'b0, 1'b0, 1'b0);
    send(16'd9, 16'd9, 40'd2, 1'b0, 1'b1, 1'b1);
    @(posedge CLK); #1;
    check_val("pre_rst_out_valid", out_valid, 1);
    RST_N = 1'b0;
    #1;
    check_val("async_rst_out_valid", out_valid, 0);
    check_val("async_rst_mac", mac, 0);
    check_val("async_rst_ovf", ovf, 0);
    n_push -= sb.size();
    sb.delete();
    model_acc = 0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check_val("post_rst_in_ready", in_ready, 1);
    check_val("post_rst_out_valid", out_valid, 0);
    send(16'd2, 16'd3, 40'hABC, 1'b0, 1'b1, 1'b0);
    drain();
    check_val("post_rst_acc_mac", last_mac, 64'd6);

    check_val("result_count", n_out, n_push);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
